alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Issue/decode front end for the 32-bit ALU.
- Accepts one instruction per cycle over a valid/ready handshake and decodes opcode/funct into the ALU's 6-bit alucontrol code.
- Selects and extends operands, drives the combinational ALU, then registers result, zero and branch-taken into an output stage with its own valid/ready handshake.
- Two-stage pipeline (D = decode/drive, W = writeback), full throughput.

Parameters:
- size, 32, operand/result width.
- TAGW, 4, width of the opaque tag carried alongside each instruction.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept
- opcode  in  6  instruction opcode
- funct  in  6  R-type function field
- shamt  in  5  shift amount
- imm16  in  16  immediate
- rs_val  in  size  first source operand
- rt_val  in  size  second source operand
- in_tag  in  TAGW  opaque tag
- alu_a  out  size  ALU operand a (registered, D stage)
- alu_b  out  size  ALU operand b (registered, D stage)
- alucontrol  out  6  ALU operation code (registered, D stage)
- alu_result  in  size  ALU result (combinational return)
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  W stage holds a result
- out_ready  in  1  consumer accepts
- out_result  out  size  captured ALU result
- out_branch  out  1  op was a branch (codes 15..20)
- out_taken  out  1  branch taken
- out_illegal  out  1  undecodable instruction
- out_tag  out  TAGW  tag of the result
- taken_cnt  out  16  count of taken branches delivered

Behaviour:
- Reset (async, rst_n low): all outputs are 0; d_valid=0, w_valid=0, taken_cnt=0.
- Consequences of reset: in_ready=1 one cycle after release; alucontrol=0, so the ALU result is 0.
- Decode, opcode 0x00 (R-type), funct to code:
  - 0x20 add 1; 0x22 sub 2; 0x21 addu 3; 0x23 subu 4
  - 0x24 and 7; 0x25 or 8; 0x00 sll 11; 0x02 srl 12; 0x2A slt 24
- Decode, opcode to code:
  - 0x08 addi 5; 0x09 addiu 6; 0x0C andi 9; 0x0D ori 10
  - 0x23 lw 13; 0x2B sw 14; 0x0A slti 25
  - 0x04 beq 15; 0x05 bne 16; 0x07 bgt 17; 0x01 bge 18; 0x06 blt 19; 0x16 ble 20
- Any other opcode/funct: code 0, illegal=1. The op still flows through the pipeline; out_result=0.
- Operand a = rs_val, with one exception: for sll/srl, a = rt_val.
- Operand b:
  - sign-extended imm16 for codes 5, 6, 13, 14, 25
  - zero-extended imm16 for codes 9, 10
  - zero-extended shamt for codes 11, 12
  - rt_val otherwise
- Branch codes 15..20: out_branch=1 and out_taken=alu_zero. With the ALU's encodings this gives:
  - beq: taken when a==b; bne: taken when a!=b
  - bgt: taken when a>b; bge: taken when a>=b
  - blt: taken when a<b; ble: taken when a<=b
  - All comparisons are unsigned.
  - For non-branch ops, out_branch=0 and out_taken=0.
- Pipeline control:
  - advance = !w_valid || out_ready
  - in_ready = !d_valid || advance (combinational from registered state)
  - D loads on in_valid && in_ready.
  - W loads alu_result, alu_zero and the D flags when d_valid && advance.
  - d_valid clears when D advances and no new instruction is accepted.
  - w_valid clears on out_valid && out_ready when D does not refill it.
- Latency: accept at edge N puts out_valid high after edge N+1 (2 edges, accept to W load). Throughput is 1/cycle when out_ready stays high.
- Stall: with out_ready low and W full, D holds. alu_a, alu_b and alucontrol remain stable, and in_ready=0 while D is full. No data is dropped or duplicated.
- Simultaneous W drain and D refill in the same cycle is legal and required.
- taken_cnt increments on out_valid && out_ready && out_taken. It saturates at 0xFFFF.
- Reset asserted mid-operation flushes both stages immediately; in-flight ops are discarded.

Test Plan:
- Reset, then add (opcode 0x00, funct 0x20) with rs=5, rt=7, out_ready=1:
  - alucontrol=1 one cycle after accept
  - out_valid with out_result=12, out_taken=0, out_illegal=0
- addi (0x08) with rs=10, imm16=0xFFFF: alu_b=0xFFFFFFFF, out_result=9. ori (0x0D) with rs=0, imm16=0xFFFF: out_result=0x0000FFFF.
- beq with rs=rt=3: out_branch=1, out_taken=1, taken_cnt=1. bne with rs=rt=3: out_taken=0. blt with rs=2, rt=9: out_taken=1.
- Back-to-back stream of 8 ops with out_ready=1: one result per cycle, in order, tags 0..7.
- Stream with out_ready held low for 5 cycles:
  - in_ready drops once D and W are full
  - alu_a, alu_b and alucontrol are stable throughout
  - after release, all results appear in order with none lost
- Undefined opcode 0x3F: out_illegal=1, out_result=0, alucontrol=0. Assert rst_n low with both stages full: out_valid=0 and taken_cnt=0 immediately.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/decode front end for the 32-bit ALU: valid/ready intake, opcode/funct
// decode into the ALU control code, operand selection, and a registered
// writeback stage with its own valid/ready handshake.
module alu_issue_ctrl #(
    parameter int unsigned size = 32,
    parameter int unsigned TAGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [4:0]      shamt,
    input  logic [15:0]     imm16,
    input  logic [size-1:0] rs_val,
    input  logic [size-1:0] rt_val,
    input  logic [TAGW-1:0] in_tag,
    output logic [size-1:0] alu_a,
    output logic [size-1:0] alu_b,
    output logic [5:0]      alucontrol,
    input  logic [size-1:0] alu_result,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] out_result,
    output logic            out_branch,
    output logic            out_taken,
    output logic            out_illegal,
    output logic [TAGW-1:0] out_tag,
    output logic [15:0]     taken_cnt
);

    localparam int unsigned OPW  = 6;
    localparam int unsigned IMMW = 16;
    localparam int unsigned CNTW = 16;

    // Opcodes
    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPW-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;
    localparam logic [OPW-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPW-1:0] OP_BNE   = 6'h05;
    localparam logic [OPW-1:0] OP_BGT   = 6'h07;
    localparam logic [OPW-1:0] OP_BGE   = 6'h01;
    localparam logic [OPW-1:0] OP_BLT   = 6'h06;
    localparam logic [OPW-1:0] OP_BLE   = 6'h16;

    // R-type function fields
    localparam logic [OPW-1:0] FN_ADD  = 6'h20;
    localparam logic [OPW-1:0] FN_SUB  = 6'h22;
    localparam logic [OPW-1:0] FN_ADDU = 6'h21;
    localparam logic [OPW-1:0] FN_SUBU = 6'h23;
    localparam logic [OPW-1:0] FN_AND  = 6'h24;
    localparam logic [OPW-1:0] FN_OR   = 6'h25;
    localparam logic [OPW-1:0] FN_SLL  = 6'h00;
    localparam logic [OPW-1:0] FN_SRL  = 6'h02;
    localparam logic [OPW-1:0] FN_SLT  = 6'h2A;

    // ALU control codes
    localparam logic [OPW-1:0] C_NONE  = 6'd0;
    localparam logic [OPW-1:0] C_ADD   = 6'd1;
    localparam logic [OPW-1:0] C_SUB   = 6'd2;
    localparam logic [OPW-1:0] C_ADDU  = 6'd3;
    localparam logic [OPW-1:0] C_SUBU  = 6'd4;
    localparam logic [OPW-1:0] C_ADDI  = 6'd5;
    localparam logic [OPW-1:0] C_ADDIU = 6'd6;
    localparam logic [OPW-1:0] C_AND   = 6'd7;
    localparam logic [OPW-1:0] C_OR    = 6'd8;
    localparam logic [OPW-1:0] C_ANDI  = 6'd9;
    localparam logic [OPW-1:0] C_ORI   = 6'd10;
    localparam logic [OPW-1:0] C_SLL   = 6'd11;
    localparam logic [OPW-1:0] C_SRL   = 6'd12;
    localparam logic [OPW-1:0] C_LW    = 6'd13;
    localparam logic [OPW-1:0] C_SW    = 6'd14;
    localparam logic [OPW-1:0] C_BEQ   = 6'd15;
    localparam logic [OPW-1:0] C_BNE   = 6'd16;
    localparam logic [OPW-1:0] C_BGT   = 6'd17;
    localparam logic [OPW-1:0] C_BGE   = 6'd18;
    localparam logic [OPW-1:0] C_BLT   = 6'd19;
    localparam logic [OPW-1:0] C_BLE   = 6'd20;
    localparam logic [OPW-1:0] C_SLT   = 6'd24;
    localparam logic [OPW-1:0] C_SLTI  = 6'd25;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    // Decode results (combinational)
    logic [OPW-1:0]  dec_code_c;
    logic            dec_illegal_c;
    logic            dec_branch_c;
    logic [size-1:0] dec_a_c;
    logic [size-1:0] dec_b_c;
    logic [size-1:0] imm_sext_c;
    logic [size-1:0] imm_zext_c;
    logic [size-1:0] shamt_zext_c;

    // Handshake
    logic advance_c;
    logic accept_c;

    // Intake enable: low in reset, high from the first edge after release
    logic rdy_q, rdy_d;

    // D stage
    logic            d_valid_q, d_valid_d;
    logic [size-1:0] alu_a_q, alu_a_d;
    logic [size-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]  alucontrol_q, alucontrol_d;
    logic            d_illegal_q, d_illegal_d;
    logic            d_branch_q, d_branch_d;
    logic [TAGW-1:0] d_tag_q, d_tag_d;

    // W stage
    logic            w_valid_q, w_valid_d;
    logic [size-1:0] w_result_q, w_result_d;
    logic            w_branch_q, w_branch_d;
    logic            w_taken_q, w_taken_d;
    logic            w_illegal_q, w_illegal_d;
    logic [TAGW-1:0] w_tag_q, w_tag_d;
    logic [CNTW-1:0] taken_cnt_q, taken_cnt_d;

    // Immediate / shift-amount extensions
    always_comb begin
        imm_sext_c   = {{(size-IMMW){imm16[IMMW-1]}}, imm16};
        imm_zext_c   = size'(imm16);
        shamt_zext_c = size'(shamt);
    end

    // Opcode/funct decode and operand selection
    always_comb begin
        dec_code_c    = C_NONE;
        dec_illegal_c = 1'b0;
        dec_a_c       = rs_val;
        dec_b_c       = rt_val;

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec_code_c = C_ADD;
                    FN_SUB:  dec_code_c = C_SUB;
                    FN_ADDU: dec_code_c = C_ADDU;
                    FN_SUBU: dec_code_c = C_SUBU;
                    FN_AND:  dec_code_c = C_AND;
                    FN_OR:   dec_code_c = C_OR;
                    FN_SLL:  dec_code_c = C_SLL;
                    FN_SRL:  dec_code_c = C_SRL;
                    FN_SLT:  dec_code_c = C_SLT;
                    default: dec_illegal_c = 1'b1;
                endcase
            end
            OP_ADDI:  dec_code_c = C_ADDI;
            OP_ADDIU: dec_code_c = C_ADDIU;
            OP_ANDI:  dec_code_c = C_ANDI;
            OP_ORI:   dec_code_c = C_ORI;
            OP_LW:    dec_code_c = C_LW;
            OP_SW:    dec_code_c = C_SW;
            OP_SLTI:  dec_code_c = C_SLTI;
            OP_BEQ:   dec_code_c = C_BEQ;
            OP_BNE:   dec_code_c = C_BNE;
            OP_BGT:   dec_code_c = C_BGT;
            OP_BGE:   dec_code_c = C_BGE;
            OP_BLT:   dec_code_c = C_BLT;
            OP_BLE:   dec_code_c = C_BLE;
            default:  dec_illegal_c = 1'b1;
        endcase

        case (dec_code_c)
            C_ADDI, C_ADDIU, C_LW, C_SW, C_SLTI: dec_b_c = imm_sext_c;
            C_ANDI, C_ORI:                       dec_b_c = imm_zext_c;
            C_SLL, C_SRL: begin
                // Shifts operate on rt; rs is not an operand
                dec_a_c = rt_val;
                dec_b_c = shamt_zext_c;
            end
            default:                             dec_b_c = rt_val;
        endcase

        dec_branch_c = (dec_code_c >= C_BEQ) && (dec_code_c <= C_BLE);
    end

    // Pipeline handshake
    always_comb begin
        advance_c = !w_valid_q || out_ready;
        in_ready  = rdy_q && (!d_valid_q || advance_c);
        accept_c  = in_valid && in_ready;
    end

    // D stage next state
    always_comb begin
        rdy_d        = 1'b1;
        d_valid_d    = d_valid_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alucontrol_d = alucontrol_q;
        d_illegal_d  = d_illegal_q;
        d_branch_d   = d_branch_q;
        d_tag_d      = d_tag_q;

        if (accept_c) begin
            d_valid_d    = 1'b1;
            alu_a_d      = dec_a_c;
            alu_b_d      = dec_b_c;
            alucontrol_d = dec_code_c;
            d_illegal_d  = dec_illegal_c;
            d_branch_d   = dec_branch_c;
            d_tag_d      = in_tag;
        end else if (advance_c) begin
            d_valid_d    = 1'b0;
        end
    end

    // W stage and taken-branch counter next state
    always_comb begin
        w_valid_d   = w_valid_q;
        w_result_d  = w_result_q;
        w_branch_d  = w_branch_q;
        w_taken_d   = w_taken_q;
        w_illegal_d = w_illegal_q;
        w_tag_d     = w_tag_q;
        taken_cnt_d = taken_cnt_q;

        if (d_valid_q && advance_c) begin
            w_valid_d   = 1'b1;
            w_result_d  = d_illegal_q ? '0 : alu_result;
            w_branch_d  = d_branch_q;
            w_taken_d   = d_branch_q && alu_zero;
            w_illegal_d = d_illegal_q;
            w_tag_d     = d_tag_q;
        end else if (out_ready) begin
            w_valid_d   = 1'b0;
        end

        if (w_valid_q && out_ready && w_taken_q && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + CNTW'(1);
        end
    end

    // D stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q        <= 1'b0;
            d_valid_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alucontrol_q <= C_NONE;
            d_illegal_q  <= 1'b0;
            d_branch_q   <= 1'b0;
            d_tag_q      <= '0;
        end else begin
            rdy_q        <= rdy_d;
            d_valid_q    <= d_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alucontrol_q <= alucontrol_d;
            d_illegal_q  <= d_illegal_d;
            d_branch_q   <= d_branch_d;
            d_tag_q      <= d_tag_d;
        end
    end

    // W stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid_q   <= 1'b0;
            w_result_q  <= '0;
            w_branch_q  <= 1'b0;
            w_taken_q   <= 1'b0;
            w_illegal_q <= 1'b0;
            w_tag_q     <= '0;
            taken_cnt_q <= '0;
        end else begin
            w_valid_q   <= w_valid_d;
            w_result_q  <= w_result_d;
            w_branch_q  <= w_branch_d;
            w_taken_q   <= w_taken_d;
            w_illegal_q <= w_illegal_d;
            w_tag_q     <= w_tag_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Output drive
    always_comb begin
        alu_a       = alu_a_q;
        alu_b       = alu_b_q;
        alucontrol  = alucontrol_q;
        out_valid   = w_valid_q;
        out_result  = w_result_q;
        out_branch  = w_branch_q;
        out_taken   = w_taken_q;
        out_illegal = w_illegal_q;
        out_tag     = w_tag_q;
        taken_cnt   = taken_cnt_q;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: combinational ALU stand-in, instruction-level
// reference model with an in-flight queue, per-cycle compare, directed and
// random stimulus.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [3:0]  in_tag;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alucontrol;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_branch;
    logic        out_taken;
    logic        out_illegal;
    logic [3:0]  out_tag;
    logic [15:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.size(32), .TAGW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .shamt(shamt), .imm16(imm16),
        .rs_val(rs_val), .rt_val(rt_val), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alucontrol(alucontrol),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_branch(out_branch), .out_taken(out_taken),
        .out_illegal(out_illegal), .out_tag(out_tag), .taken_cnt(taken_cnt)
    );

    // Stand-in for the real ALU: result and zero flag from code, a, b
    always_comb begin
        alu_result = 32'h0;
        case (alucontrol)
            6'd1, 6'd3, 6'd5, 6'd6, 6'd13, 6'd14: alu_result = alu_a + alu_b;
            6'd2, 6'd4:                           alu_result = alu_a - alu_b;
            6'd7, 6'd9:                           alu_result = alu_a & alu_b;
            6'd8, 6'd10:                          alu_result = alu_a | alu_b;
            6'd11: alu_result = alu_a << alu_b[4:0];
            6'd12: alu_result = alu_a >> alu_b[4:0];
            6'd24, 6'd25: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            6'd15, 6'd16, 6'd17, 6'd18, 6'd19, 6'd20: alu_result = alu_a - alu_b;
            default: alu_result = 32'h0;
        endcase
        case (alucontrol)
            6'd15:   alu_zero = (alu_a == alu_b);
            6'd16:   alu_zero = (alu_a != alu_b);
            6'd17:   alu_zero = (alu_a >  alu_b);
            6'd18:   alu_zero = (alu_a >= alu_b);
            6'd19:   alu_zero = (alu_a <  alu_b);
            6'd20:   alu_zero = (alu_a <= alu_b);
            default: alu_zero = (alu_result == 32'h0);
        endcase
    end

    typedef struct {
        int          acc;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  code;
        logic [31:0] res;
        logic        br;
        logic        tk;
        logic        ill;
        logic [3:0]  tag;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    bit          up = 1'b0;
    logic [15:0] cnt_m = 16'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Instruction-level semantics: what the op means, not how it is decoded
    function automatic exp_t predict(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] sh, input logic [15:0] imm,
                                     input logic [31:0] rs, input logic [31:0] rt,
                                     input logic [3:0] tag);
        exp_t e;
        logic [31:0] se;
        logic [31:0] ze;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        e.acc = 0; e.a = rs; e.b = rt; e.code = 6'd0; e.res = 32'h0;
        e.br = 1'b0; e.tk = 1'b0; e.ill = 1'b0; e.tag = tag;
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin e.code = 6'd1;  e.res = rs + rt; end
                6'h22: begin e.code = 6'd2;  e.res = rs - rt; end
                6'h21: begin e.code = 6'd3;  e.res = rs + rt; end
                6'h23: begin e.code = 6'd4;  e.res = rs - rt; end
                6'h24: begin e.code = 6'd7;  e.res = rs & rt; end
                6'h25: begin e.code = 6'd8;  e.res = rs | rt; end
                6'h00: begin e.code = 6'd11; e.a = rt; e.b = {27'h0, sh}; e.res = rt << sh; end
                6'h02: begin e.code = 6'd12; e.a = rt; e.b = {27'h0, sh}; e.res = rt >> sh; end
                6'h2A: begin e.code = 6'd24; e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
                default: e.ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08: begin e.code = 6'd5;  e.b = se; e.res = rs + se; end
                6'h09: begin e.code = 6'd6;  e.b = se; e.res = rs + se; end
                6'h0C: begin e.code = 6'd9;  e.b = ze; e.res = rs & ze; end
                6'h0D: begin e.code = 6'd10; e.b = ze; e.res = rs | ze; end
                6'h23: begin e.code = 6'd13; e.b = se; e.res = rs + se; end
                6'h2B: begin e.code = 6'd14; e.b = se; e.res = rs + se; end
                6'h0A: begin e.code = 6'd25; e.b = se; e.res = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0; end
                6'h04: begin e.code = 6'd15; e.br = 1'b1; e.tk = (rs == rt); e.res = rs - rt; end
                6'h05: begin e.code = 6'd16; e.br = 1'b1; e.tk = (rs != rt); e.res = rs - rt; end
                6'h07: begin e.code = 6'd17; e.br = 1'b1; e.tk = (rs >  rt); e.res = rs - rt; end
                6'h01: begin e.code = 6'd18; e.br = 1'b1; e.tk = (rs >= rt); e.res = rs - rt; end
                6'h06: begin e.code = 6'd19; e.br = 1'b1; e.tk = (rs <  rt); e.res = rs - rt; end
                6'h16: begin e.code = 6'd20; e.br = 1'b1; e.tk = (rs <= rt); e.res = rs - rt; end
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Model update: ops in flight in order; the oldest is deliverable one edge after accept
    always @(posedge clk) begin : model
        bit   drain;
        bit   take;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            cyc   = 0;
            up    = 1'b0;
            cnt_m = 16'h0;
        end else begin
            drain = (q.size() > 0) && (q[0].acc < cyc) && out_ready;
            take  = in_valid && up && ((q.size() < 2) || out_ready);
            if (drain) begin
                if (q[0].tk && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
                void'(q.pop_front());
            end
            cyc++;
            if (take) begin
                e = predict(opcode, funct, shamt, imm16, rs_val, rt_val, in_tag);
                e.acc = cyc;
                q.push_back(e);
            end
            up = 1'b1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin : compare
        exp_t h;
        exp_t t;
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_taken_cnt", 32'(taken_cnt), 32'h0);
            chk("rst_alucontrol", 32'(alucontrol), 32'h0);
            chk("rst_out_result", out_result, 32'h0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(up && ((q.size() < 2) || out_ready)));
            chk("out_valid", 32'(out_valid), 32'((q.size() > 0) && (q[0].acc < cyc)));
            if ((q.size() > 0) && (q[0].acc < cyc)) begin
                h = q[0];
                chk("out_result", out_result, h.res);
                chk("out_branch", 32'(out_branch), 32'(h.br));
                chk("out_taken", 32'(out_taken), 32'(h.tk));
                chk("out_illegal", 32'(out_illegal), 32'(h.ill));
                chk("out_tag", 32'(out_tag), 32'(h.tag));
            end
            chk("taken_cnt", 32'(taken_cnt), 32'(cnt_m));
            if (q.size() > 0) begin
                t = q[q.size()-1];
                if ((t.acc == cyc) || (q.size() == 2)) begin
                    chk("alu_a", alu_a, t.a);
                    chk("alu_b", alu_b, t.b);
                    chk("alucontrol", 32'(alucontrol), 32'(t.code));
                end
            end
        end
    end

    // Present one instruction and hold it until accepted (bounded)
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [3:0] tag);
        int n;
        @(posedge clk); #1;
        opcode = op; funct = fn; shamt = sh; imm16 = imm;
        rs_val = rs; rt_val = rt; in_tag = tag; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed 0 for tag %0d", tag);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Random instruction selection over legal and illegal encodings
    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        int k;
        k  = int'($urandom_range(0, 24));
        op = 6'h00;
        fn = 6'h00;
        case (k)
            0: fn = 6'h20;  1: fn = 6'h22;  2: fn = 6'h21;  3: fn = 6'h23;
            4: fn = 6'h24;  5: fn = 6'h25;  6: fn = 6'h00;  7: fn = 6'h02;
            8: fn = 6'h2A;
            9: op = 6'h08;  10: op = 6'h09; 11: op = 6'h0C; 12: op = 6'h0D;
            13: op = 6'h23; 14: op = 6'h2B; 15: op = 6'h0A;
            16: op = 6'h04; 17: op = 6'h05; 18: op = 6'h07; 19: op = 6'h01;
            20: op = 6'h06; 21: op = 6'h16;
            22: op = 6'h3F;
            23: fn = 6'h3F;
            default: op = 6'h02;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 6'h0; funct = 6'h0; shamt = 5'h0; imm16 = 16'h0;
        rs_val = 32'h0; rt_val = 32'h0; in_tag = 4'h0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", 32'(in_ready), 32'h1);

        // add 5+7
        issue(6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, 4'd0);
        @(negedge clk);
        chk("add_alucontrol", 32'(alucontrol), 32'd1);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        @(negedge clk);
        chk("add_out_valid", 32'(out_valid), 32'h1);
        chk("add_result", out_result, 32'd12);
        chk("add_taken", 32'(out_taken), 32'h0);
        chk("add_illegal", 32'(out_illegal), 32'h0);

        // addi with negative immediate, ori with zero-extended immediate
        issue(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd10, 32'd0, 4'd1);
        @(negedge clk);
        chk("addi_alu_b", alu_b, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("addi_result", out_result, 32'd9);
        issue(6'h0D, 6'h00, 5'd0, 16'hFFFF, 32'd0, 32'd0, 4'd2);
        @(negedge clk);
        @(negedge clk);
        chk("ori_result", out_result, 32'h0000_FFFF);

        // Branches
        issue(6'h04, 6'h00, 5'd0, 16'h0, 32'd3, 32'd3, 4'd3);
        @(negedge clk);
        @(negedge clk);
        chk("beq_branch", 32'(out_branch), 32'h1);
        chk("beq_taken", 32'(out_taken), 32'h1);
        @(negedge clk);
        chk("beq_taken_cnt", 32'(taken_cnt), 32'd1);
        issue(6'h05, 6'h00, 5'd0, 16'h0, 32'd3, 32'd3, 4'd4);
        @(negedge clk);
        @(negedge clk);
        chk("bne_branch", 32'(out_branch), 32'h1);
        chk("bne_taken", 32'(out_taken), 32'h0);
        issue(6'h06, 6'h00, 5'd0, 16'h0, 32'd2, 32'd9, 4'd5);
        @(negedge clk);
        @(negedge clk);
        chk("blt_taken", 32'(out_taken), 32'h1);
        @(negedge clk);
        chk("blt_taken_cnt", 32'(taken_cnt), 32'd2);

        // Back-to-back stream of 8
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk); #1;
                    opcode = 6'h00; funct = 6'h20; rs_val = 32'(i); rt_val = 32'd100;
                    in_tag = 4'(i); in_valid = 1'b1;
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                int first;
                int last;
                int nexp;
                first = -1; last = -1; nexp = 0;
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        chk("stream_tag", 32'(out_tag), 32'(nexp));
                        chk("stream_result", out_result, 32'(nexp + 100));
                        if (first < 0) first = k;
                        last = k;
                        nexp++;
                    end
                end
                chk("stream_count", 32'(nexp), 32'd8);
                chk("stream_span", 32'(last - first), 32'd7);
            end
        join

        // Stall with out_ready low
        @(posedge clk); #1 out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    issue(6'h00, 6'h20, 5'd0, 16'h0, 32'(1000 + k), 32'd1, 4'(8 + k));
            end
            begin
                repeat (6) @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'h0);
                chk("stall_out_valid", 32'(out_valid), 32'h1);
                chk("stall_out_tag", 32'(out_tag), 32'd8);
                chk("stall_alu_a", alu_a, 32'd1001);
                chk("stall_alucontrol", 32'(alucontrol), 32'd1);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);

        // Undefined opcode
        issue(6'h3F, 6'h00, 5'd0, 16'h1234, 32'd77, 32'd88, 4'd12);
        @(negedge clk);
        chk("illegal_alucontrol", 32'(alucontrol), 32'h0);
        @(negedge clk);
        chk("illegal_flag", 32'(out_illegal), 32'h1);
        chk("illegal_result", out_result, 32'h0);

        // Reset with both stages full
        @(posedge clk); #1 out_ready = 1'b0;
        issue(6'h04, 6'h00, 5'd0, 16'h0, 32'd4, 32'd4, 4'd13);
        issue(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd1, 4'd14);
        @(negedge clk);
        chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
        chk("pre_rst_taken_cnt", 32'(taken_cnt), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_taken_cnt", 32'(taken_cnt), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            pick(op, fn);
            opcode    = op;
            funct     = fn;
            shamt     = 5'($urandom);
            imm16     = 16'($urandom);
            rs_val    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rt_val    = ($urandom_range(0, 3) == 0) ? rs_val :
                        (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
            in_tag    = 4'(i);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drained_out_valid", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
